// File: rtl/frame_buffer.sv
// Double-buffered 3-bit pixel store feeding the LED matrix shifter: the host fills the back bank,
// the display reads the front bank, and banks exchange only at a frame boundary. Optional: TEST_PATTERN_EN.
module frame_buffer #(
  parameter int NUM_PANELS = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] col,
  input  logic [2:0] row,
  input  logic       wr_valid,
  output logic       wr_ready,
  input  logic [7:0] wr_x,
  input  logic [3:0] wr_y,
  input  logic [2:0] wr_rgb,
  input  logic       swap_req,
  output logic       swap_done,
  output logic       front,
  output logic [2:0] rgb1,
  output logic [2:0] rgb2,
`ifdef TEST_PATTERN_EN
  input  logic       test_mode,
`endif
  output logic       dbg_state
);

  localparam int unsigned W     = 32 * NUM_PANELS;
  localparam int unsigned DEPTH = 16 * W;
  localparam int          AW    = $clog2(2 * DEPTH);

  typedef enum logic {
    S_IDLE    = 1'b0,
    S_PENDING = 1'b1
  } state_t;

  state_t         state;
  logic [2:0]     row_q;
  logic           boundary;
  logic           wr_fire;
  logic           col_ok;
  logic [AW-1:0]  waddr;
  logic [AW-1:0]  raddr1;
  logic [AW-1:0]  raddr2;
  logic [2:0]     mem [0:2*DEPTH-1];

  // Write handshake: a write is taken on any rising edge where wr_valid and wr_ready are both 1;
  // wr_valid may be held across cycles, and wr_ready is a registered function of the swap state only.
  always_comb begin
    boundary  = (row_q == 3'd7) && (row == 3'd0);
    wr_fire   = wr_valid && wr_ready && (32'(wr_x) < W);
    col_ok    = 32'(col) < W;
    waddr     = AW'((front ? 32'd0 : DEPTH) + 32'(wr_y) * W + 32'(wr_x));
    raddr1    = AW'((front ? DEPTH : 32'd0) + 32'(row) * W + 32'(col));
    raddr2    = AW'((front ? DEPTH : 32'd0) + (32'(row) + 32'd8) * W + 32'(col));
    dbg_state = (state == S_PENDING);
  end

  always_ff @(posedge clk) begin
    if (wr_fire) begin
      mem[waddr] <= wr_rgb;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rgb1 <= 3'b000;
      rgb2 <= 3'b000;
`ifdef TEST_PATTERN_EN
    end else if (test_mode) begin
      rgb1 <= col[2:0];
      rgb2 <= ~col[2:0];
`endif
    end else if (col_ok) begin
      rgb1 <= mem[raddr1];
      rgb2 <= mem[raddr2];
    end else begin
      rgb1 <= 3'b000;
      rgb2 <= 3'b000;
    end
  end

  // A request seen in IDLE always waits for a later boundary, even if one occurs this very cycle.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= S_IDLE;
      front     <= 1'b0;
      swap_done <= 1'b0;
      wr_ready  <= 1'b1;
      row_q     <= 3'd0;
    end else begin
      row_q     <= row;
      swap_done <= 1'b0;
      case (state)
        S_IDLE: begin
          if (swap_req) begin
            state    <= S_PENDING;
            wr_ready <= 1'b0;
          end
        end
        S_PENDING: begin
          if (boundary) begin
            state     <= S_IDLE;
            front     <= ~front;
            swap_done <= 1'b1;
            wr_ready  <= 1'b1;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_frame_buffer.sv
// Bench for frame_buffer: random and directed stimulus against a bank-array reference model.
// Builds with or without TEST_PATTERN_EN.
module tb_frame_buffer;

  localparam int W = 32;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] col = '0;
  logic [2:0] row = '0;
  logic       wr_valid = 1'b0;
  logic       wr_ready;
  logic [7:0] wr_x = '0;
  logic [3:0] wr_y = '0;
  logic [2:0] wr_rgb = '0;
  logic       swap_req = 1'b0;
  logic       swap_done;
  logic       front;
  logic [2:0] rgb1;
  logic [2:0] rgb2;
  logic       dbg_state;
`ifdef TEST_PATTERN_EN
  logic       test_mode = 1'b0;
`endif

  frame_buffer #(.NUM_PANELS(1)) dut (
    .clk(clk), .rst(rst), .col(col), .row(row),
    .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_x(wr_x), .wr_y(wr_y), .wr_rgb(wr_rgb),
    .swap_req(swap_req), .swap_done(swap_done), .front(front), .rgb1(rgb1), .rgb2(rgb2),
`ifdef TEST_PATTERN_EN
    .test_mode(test_mode),
`endif
    .dbg_state(dbg_state)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  // Reference model: two pixel banks plus which one is shown and whether a swap is owed.
  logic [2:0] m_mem [2][16][W];
  bit         m_front = 1'b0;
  bit         m_pending = 1'b0;
  logic [2:0] m_prev_row = 3'd0;
  logic [2:0] e_rgb1 = 3'd0;
  logic [2:0] e_rgb2 = 3'd0;
  bit         e_swap_done = 1'b0;

  task automatic step();
    logic [2:0] r1;
    logic [2:0] r2;
    int         b;
    b  = m_front ? 1 : 0;
    r1 = 3'd0;
    r2 = 3'd0;
    if (int'(col) < W) begin
      r1 = m_mem[b][int'(row)][int'(col)];
      r2 = m_mem[b][int'(row) + 8][int'(col)];
    end
`ifdef TEST_PATTERN_EN
    if (test_mode) begin
      r1 = col[2:0];
      r2 = ~col[2:0];
    end
`endif
    if (wr_valid && !m_pending && int'(wr_x) < W)
      m_mem[1 - b][int'(wr_y)][int'(wr_x)] = wr_rgb;
    e_swap_done = 1'b0;
    if (m_pending) begin
      if (m_prev_row == 3'd7 && row == 3'd0) begin
        m_front     = !m_front;
        m_pending   = 1'b0;
        e_swap_done = 1'b1;
      end
    end else if (swap_req) begin
      m_pending = 1'b1;
    end
    m_prev_row = row;
    @(posedge clk);
    #1;
    e_rgb1 = r1;
    e_rgb2 = r2;
  endtask

  task automatic do_swap();
    wr_valid = 1'b0;
    swap_req = 1'b1; row = 3'd3; step();
    swap_req = 1'b0; row = 3'd7; step();
    row = 3'd0; step();
  endtask

  task automatic test_reset();
    #2 rst = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    if (rgb1 !== 3'b000) begin n_err++; $display("FAIL reset_rgb1 got %b exp 000", rgb1); end
    if (rgb2 !== 3'b000) begin n_err++; $display("FAIL reset_rgb2 got %b exp 000", rgb2); end
    if (front !== 1'b0) begin n_err++; $display("FAIL reset_front got %b exp 0", front); end
    if (wr_ready !== 1'b1) begin n_err++; $display("FAIL reset_wr_ready got %b exp 1", wr_ready); end
    if (swap_done !== 1'b0) begin n_err++; $display("FAIL reset_swap_done got %b exp 0", swap_done); end
    if (dbg_state !== 1'b0) begin n_err++; $display("FAIL reset_state got %b exp 0", dbg_state); end
    n_vec += 6;
    rst = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic fill_back_bank();
    row = 3'd3;
    for (int y = 0; y < 16; y++) begin
      for (int x = 0; x < W; x++) begin
        wr_valid = 1'b1; wr_x = 8'(x); wr_y = 4'(y); wr_rgb = 3'($urandom_range(7));
        step();
        if (wr_ready !== 1'b1) begin n_err++; $display("FAIL b2b_wr_ready got %b exp 1", wr_ready); end
        n_vec++;
      end
    end
    wr_valid = 1'b0;
  endtask

  task automatic test_back_to_back();
    fill_back_bank();
    do_swap();
    if (front !== 1'b1) begin n_err++; $display("FAIL b2b_front1 got %b exp 1", front); end
    n_vec++;
    fill_back_bank();
    do_swap();
    if (front !== 1'b0) begin n_err++; $display("FAIL b2b_front0 got %b exp 0", front); end
    n_vec++;
  endtask

  task automatic test_write_swap_read();
    row = 3'd3;
    wr_valid = 1'b1; wr_x = 8'd5; wr_y = 4'd2; wr_rgb = 3'b101; step();
    wr_y = 4'd10; wr_rgb = 3'b011; step();
    wr_valid = 1'b0;
    swap_req = 1'b1; step();
    swap_req = 1'b0;
    if (wr_ready !== 1'b0) begin n_err++; $display("FAIL wsr_wr_ready got %b exp 0", wr_ready); end
    row = 3'd7; step();
    if (swap_done !== 1'b0) begin n_err++; $display("FAIL wsr_early_done got %b exp 0", swap_done); end
    row = 3'd0; step();
    if (swap_done !== 1'b1) begin n_err++; $display("FAIL wsr_swap_done got %b exp 1", swap_done); end
    if (front !== 1'b1) begin n_err++; $display("FAIL wsr_front got %b exp 1", front); end
    row = 3'd1; step();
    if (swap_done !== 1'b0) begin n_err++; $display("FAIL wsr_done_len got %b exp 0", swap_done); end
    col = 8'd5; row = 3'd2; step();
    if (rgb1 !== 3'b101) begin n_err++; $display("FAIL wsr_rgb1 got %b exp 101", rgb1); end
    if (rgb2 !== 3'b011) begin n_err++; $display("FAIL wsr_rgb2 got %b exp 011", rgb2); end
    n_vec += 7;
  endtask

  task automatic test_backpressure();
    logic [7:0] xs [$];
    logic [3:0] ys [$];
    int         b;
    b = m_front ? 0 : 1;
    swap_req = 1'b1; row = 3'd4; step();
    swap_req = 1'b0;
    for (int i = 0; i < 6; i++) begin
      wr_valid = 1'b1; wr_x = 8'($urandom_range(W - 1)); wr_y = 4'($urandom_range(15));
      wr_rgb = ~m_mem[b][int'(wr_y)][int'(wr_x)];
      xs.push_back(wr_x); ys.push_back(wr_y);
      if (wr_ready !== 1'b0) begin n_err++; $display("FAIL bp_wr_ready got %b exp 0", wr_ready); end
      n_vec++;
      row = 3'd5; step();
    end
    row = 3'd7; step();
    row = 3'd0; step();
    wr_valid = 1'b0;
    if (swap_done !== 1'b1) begin n_err++; $display("FAIL bp_swap_done got %b exp 1", swap_done); end
    row = 3'd1; step();
    if (wr_ready !== 1'b1) begin n_err++; $display("FAIL bp_ready_after got %b exp 1", wr_ready); end
    n_vec += 2;
    while (xs.size() > 0) begin
      logic [7:0] x;
      logic [3:0] y;
      x = xs.pop_front(); y = ys.pop_front();
      col = x; row = y[2:0]; step();
      if ((y[3] ? rgb2 : rgb1) !== (y[3] ? e_rgb2 : e_rgb1)) begin
        n_err++;
        $display("FAIL bp_blocked_write x=%0d y=%0d got %b exp %b", x, y, y[3] ? rgb2 : rgb1,
                 y[3] ? e_rgb2 : e_rgb1);
      end
      n_vec++;
    end
  endtask

  task automatic test_swap_edge();
    bit f0;
    f0 = m_front;
    row = 3'd7; step();
    row = 3'd0; swap_req = 1'b1; step();
    swap_req = 1'b0;
    if (swap_done !== 1'b0) begin n_err++; $display("FAIL edge_no_swap got %b exp 0", swap_done); end
    if (front !== f0) begin n_err++; $display("FAIL edge_front_hold got %b exp %b", front, f0); end
    if (wr_ready !== 1'b0) begin n_err++; $display("FAIL edge_pending got %b exp 0", wr_ready); end
    row = 3'd3; step();
    row = 3'd4; swap_req = 1'b1; step();
    swap_req = 1'b0;
    row = 3'd7; step();
    row = 3'd0; step();
    if (swap_done !== 1'b1) begin n_err++; $display("FAIL edge_swap_done got %b exp 1", swap_done); end
    if (front !== !f0) begin n_err++; $display("FAIL edge_front_toggle got %b exp %b", front, !f0); end
    row = 3'd1; step();
    row = 3'd7; step();
    row = 3'd0; step();
    if (swap_done !== 1'b0) begin n_err++; $display("FAIL edge_no_queue got %b exp 0", swap_done); end
    if (front !== !f0) begin n_err++; $display("FAIL edge_one_toggle got %b exp %b", front, !f0); end
    n_vec += 7;
  endtask

  task automatic test_out_of_range();
    int b;
    b = m_front ? 0 : 1;
    row = 3'd3;
    wr_valid = 1'b1; wr_x = 8'd40; wr_y = 4'd3; wr_rgb = ~m_mem[b][4][8]; step();
    wr_x = 8'(W); wr_y = 4'd15; wr_rgb = ~m_mem[1 - b][0][0]; step();
    wr_valid = 1'b0;
    col = 8'd0; row = 3'd0; step();
    if (rgb1 !== e_rgb1) begin n_err++; $display("FAIL oor_front_alias got %b exp %b", rgb1, e_rgb1); end
    do_swap();
    col = 8'd8; row = 3'd4; step();
    if (rgb1 !== e_rgb1) begin n_err++; $display("FAIL oor_back_alias got %b exp %b", rgb1, e_rgb1); end
    col = 8'd33; row = 3'd2; step();
    if (rgb1 !== 3'b000) begin n_err++; $display("FAIL oor_col33_rgb1 got %b exp 000", rgb1); end
    if (rgb2 !== 3'b000) begin n_err++; $display("FAIL oor_col33_rgb2 got %b exp 000", rgb2); end
    col = 8'd255; step();
    if (rgb1 !== 3'b000 || rgb2 !== 3'b000) begin
      n_err++; $display("FAIL oor_col255 got %b/%b exp 000/000", rgb1, rgb2);
    end
    n_vec += 5;
  endtask

  task automatic test_random(input int cycles);
    for (int i = 0; i < cycles; i++) begin
      if ($urandom_range(3) != 0) row = row + 3'd1;
      else row = 3'($urandom_range(7));
      col      = 8'($urandom_range(W + 7));
      wr_valid = 1'($urandom_range(1));
      wr_x     = 8'($urandom_range(W + 3));
      wr_y     = 4'($urandom_range(15));
      wr_rgb   = 3'($urandom_range(7));
      swap_req = ($urandom_range(19) == 0);
`ifdef TEST_PATTERN_EN
      test_mode = ($urandom_range(7) == 0);
`endif
      step();
      if (rgb1 !== e_rgb1) begin n_err++; $display("FAIL rand_rgb1 cyc=%0d got %b exp %b", i, rgb1, e_rgb1); end
      if (rgb2 !== e_rgb2) begin n_err++; $display("FAIL rand_rgb2 cyc=%0d got %b exp %b", i, rgb2, e_rgb2); end
      if (front !== m_front) begin n_err++; $display("FAIL rand_front cyc=%0d got %b exp %b", i, front, m_front); end
      if (swap_done !== e_swap_done) begin
        n_err++; $display("FAIL rand_swap_done cyc=%0d got %b exp %b", i, swap_done, e_swap_done);
      end
      if (wr_ready !== !m_pending) begin
        n_err++; $display("FAIL rand_wr_ready cyc=%0d got %b exp %b", i, wr_ready, !m_pending);
      end
      if (dbg_state !== m_pending) begin
        n_err++; $display("FAIL rand_state cyc=%0d got %b exp %b", i, dbg_state, m_pending);
      end
      n_vec += 6;
    end
    swap_req = 1'b0; wr_valid = 1'b0;
`ifdef TEST_PATTERN_EN
    test_mode = 1'b0;
`endif
  endtask

  task automatic test_reset_midrun();
    if (!m_front) do_swap();
    row = 3'd2; swap_req = 1'b1; step();
    swap_req = 1'b0;
    #3 rst = 1'b0;
    #1;
    if (rgb1 !== 3'b000 || rgb2 !== 3'b000) begin
      n_err++; $display("FAIL mid_reset_rgb got %b/%b exp 000/000", rgb1, rgb2);
    end
    if (front !== 1'b0) begin n_err++; $display("FAIL mid_reset_front got %b exp 0", front); end
    if (wr_ready !== 1'b1) begin n_err++; $display("FAIL mid_reset_wr_ready got %b exp 1", wr_ready); end
    if (swap_done !== 1'b0) begin n_err++; $display("FAIL mid_reset_swap_done got %b exp 0", swap_done); end
    n_vec += 4;
    m_front = 1'b0; m_pending = 1'b0; m_prev_row = 3'd0;
    @(posedge clk); #1;
    rst = 1'b1;
    row = 3'd7; step();
    row = 3'd0; step();
    if (swap_done !== 1'b0) begin n_err++; $display("FAIL mid_reset_lost_swap got %b exp 0", swap_done); end
    if (front !== 1'b0) begin n_err++; $display("FAIL mid_reset_front_hold got %b exp 0", front); end
    n_vec += 2;
    for (int i = 0; i < 8; i++) begin
      col = 8'($urandom_range(W - 1)); row = 3'($urandom_range(7)); step();
      if (rgb1 !== e_rgb1 || rgb2 !== e_rgb2) begin
        n_err++; $display("FAIL mid_reset_ram got %b/%b exp %b/%b", rgb1, rgb2, e_rgb1, e_rgb2);
      end
      n_vec++;
    end
  endtask

`ifdef TEST_PATTERN_EN
  task automatic test_pattern();
    test_mode = 1'b1; col = 8'd6; row = 3'd1; step();
    if (rgb1 !== 3'b110) begin n_err++; $display("FAIL tp_rgb1 got %b exp 110", rgb1); end
    if (rgb2 !== 3'b001) begin n_err++; $display("FAIL tp_rgb2 got %b exp 001", rgb2); end
    col = 8'd45; step();
    if (rgb1 !== 3'b101 || rgb2 !== 3'b010) begin
      n_err++; $display("FAIL tp_col45 got %b/%b exp 101/010", rgb1, rgb2);
    end
    test_mode = 1'b0; col = 8'd6; step();
    if (rgb1 !== e_rgb1 || rgb2 !== e_rgb2) begin
      n_err++; $display("FAIL tp_ram_return got %b/%b exp %b/%b", rgb1, rgb2, e_rgb1, e_rgb2);
    end
    n_vec += 4;
  endtask
`endif

  initial begin
    test_reset();
    test_back_to_back();
    test_write_swap_read();
    test_backpressure();
    test_swap_edge();
    test_out_of_range();
    test_random(1500);
    test_reset_midrun();
`ifdef TEST_PATTERN_EN
    test_pattern();
`endif
    test_random(500);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
